// File: rtl/s2p_write_ctrl_gen2_if.sv
// Bus bundle for the serial-to-parallel write controller: configuration,
// input beat handshake and frame-buffer write port.
// Optional macro S2P_WRITE_CTRL_FLUSH_EN adds the flush request line.
interface s2p_write_ctrl_gen2_if #(
    parameter int IN_W       = 8,
    parameter int WORD_W     = 2048,
    parameter int ADDR_W     = 12,
    parameter int WRAP_CNT_W = 8
);
    logic                  start;
    logic [ADDR_W-1:0]     cfg_base;
    logic [ADDR_W-1:0]     cfg_len;
    logic                  cfg_oneshot;
    logic                  s_valid;
    logic [IN_W-1:0]       s_data;
    logic                  s_ready;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [WORD_W-1:0]     wr_data;
    logic                  busy;
    logic                  done;
    logic [WRAP_CNT_W-1:0] wrap_cnt;
`ifdef S2P_WRITE_CTRL_FLUSH_EN
    logic                  flush;
`endif

    // Controller side: consumes config and beats, drives the write port.
    modport slave (
        input  start, cfg_base, cfg_len, cfg_oneshot, s_valid, s_data,
`ifdef S2P_WRITE_CTRL_FLUSH_EN
        input  flush,
`endif
        output s_ready, wr_en, wr_addr, wr_data, busy, done, wrap_cnt
    );

    // Front-end / host side.
    modport master (
        output start, cfg_base, cfg_len, cfg_oneshot, s_valid, s_data,
`ifdef S2P_WRITE_CTRL_FLUSH_EN
        output flush,
`endif
        input  s_ready, wr_en, wr_addr, wr_data, busy, done, wrap_cnt
    );
endinterface

// File: rtl/s2p_write_ctrl_gen2.sv
// Serial-to-parallel write controller: packs IN_W-bit beats LSB-first into
// WORD_W-bit words and writes each word to a frame buffer at an address that
// runs from a latched base over a latched length, either once (one-shot) or
// wrapping continuously.
// Optional macro S2P_WRITE_CTRL_FLUSH_EN: a flush request writes out a
// partially filled word, zero-padded in its unfilled upper slots.
module s2p_write_ctrl_gen2 #(
    parameter int IN_W       = 8,
    parameter int WORD_W     = 2048,
    parameter int ADDR_W     = 12,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                clk_in,
    input  logic                reset,
    s2p_write_ctrl_gen2_if.slave bus
);

    localparam int BEATS  = WORD_W / IN_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched frame configuration
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W-1:0]     len_q;
    logic                  oneshot_q;

    // Frame progress
    logic [ADDR_W-1:0]     addr_ptr;
    logic [ADDR_W:0]       word_idx;
    logic [ADDR_W:0]       widx_inc;
    logic [ADDR_W:0]       len_words;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q;

    // Packing stage (p0) and write stage (p1)
    logic [BCNT_W-1:0]     beat_cnt_p0;
    logic [WORD_W-1:0]     acc_p0;
    logic [WORD_W-1:0]     acc_nxt;
    logic                  vld_p1;
    logic [ADDR_W-1:0]     wr_addr_p1;
    logic [WORD_W-1:0]     wr_data_p1;

    // Per-cycle control decisions
    logic                  s_ready_c;
    logic                  busy_c;
    logic                  done_c;
    logic                  accept;
    logic                  restart;
    logic                  word_last;
    logic                  flush_req;
    logic                  do_write;
    logic                  frame_end;

    // Drop one beat into its slot of the accumulator, leaving other slots intact.
    function automatic logic [WORD_W-1:0] pack_beat(
        input logic [WORD_W-1:0] acc,
        input logic [BCNT_W-1:0] slot,
        input logic [IN_W-1:0]   beat
    );
        logic [WORD_W-1:0] r;
        r = acc;
        r[int'(slot) * IN_W +: IN_W] = beat;
        return r;
    endfunction

    // Frame counter increment that sticks at all-ones.
    function automatic logic [WRAP_CNT_W-1:0] sat_inc(
        input logic [WRAP_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    // A programmed length of zero stands for the full address space.
    assign len_words = (len_q == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_q};
    assign widx_inc  = word_idx + 1'b1;
    assign acc_nxt   = accept ? pack_beat(acc_p0, beat_cnt_p0, bus.s_data) : acc_p0;

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and the write/frame decisions for this cycle.
    always_comb begin
        state_nxt = state;
        s_ready_c = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        accept    = 1'b0;
        restart   = 1'b0;
        word_last = 1'b0;
        flush_req = 1'b0;
        do_write  = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    restart   = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                s_ready_c = 1'b1;
                busy_c    = 1'b1;
                if (bus.start) begin
                    // Restart wins: partial word and any same-cycle beat are dropped.
                    restart = 1'b1;
                end else begin
                    accept    = bus.s_valid;
                    word_last = accept && (beat_cnt_p0 == LAST_BEAT);
`ifdef S2P_WRITE_CTRL_FLUSH_EN
                    flush_req = bus.flush && (beat_cnt_p0 != '0) && !word_last;
`endif
                    do_write  = word_last || flush_req;
                    frame_end = do_write && (widx_inc == len_words);
                    // Leaving FILL here makes s_ready low in the strobe cycle.
                    if (frame_end && oneshot_q) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    restart   = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Beat packing, address/frame bookkeeping and the registered write port.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            base_q      <= '0;
            len_q       <= '0;
            oneshot_q   <= 1'b0;
            addr_ptr    <= '0;
            word_idx    <= '0;
            wrap_cnt_q  <= '0;
            beat_cnt_p0 <= '0;
            acc_p0      <= '0;
            vld_p1      <= 1'b0;
            wr_addr_p1  <= '0;
            wr_data_p1  <= '0;
        end else begin
            vld_p1 <= do_write;
            if (restart) begin
                base_q      <= bus.cfg_base;
                len_q       <= bus.cfg_len;
                oneshot_q   <= bus.cfg_oneshot;
                addr_ptr    <= bus.cfg_base;
                word_idx    <= '0;
                wrap_cnt_q  <= '0;
                beat_cnt_p0 <= '0;
                acc_p0      <= '0;
            end else if (do_write) begin
                // ---- p0 -> p1: hand the (possibly zero-padded) word to the write port
                wr_data_p1  <= acc_nxt;
                wr_addr_p1  <= addr_ptr;
                acc_p0      <= '0;
                beat_cnt_p0 <= '0;
                if (frame_end) begin
                    addr_ptr <= base_q;
                    word_idx <= '0;
                    if (!oneshot_q) begin
                        wrap_cnt_q <= sat_inc(wrap_cnt_q);
                    end
                end else begin
                    addr_ptr <= addr_ptr + 1'b1;
                    word_idx <= widx_inc;
                end
            end else if (accept) begin
                acc_p0      <= acc_nxt;
                beat_cnt_p0 <= beat_cnt_p0 + 1'b1;
            end
        end
    end

    assign bus.s_ready  = s_ready_c;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.wr_en    = vld_p1;
    assign bus.wr_addr  = wr_addr_p1;
    assign bus.wr_data  = wr_data_p1;
    assign bus.wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_s2p_write_ctrl_gen2.sv
// Directed bench for s2p_write_ctrl_gen2 with 8-bit beats, 32-bit words and
// a 4-bit address space. Flush steps are built when S2P_WRITE_CTRL_FLUSH_EN is set.
module tb_s2p_write_ctrl_gen2;

    localparam int IN_W       = 8;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 4;
    localparam int WRAP_CNT_W = 8;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    int total   = 0;
    int bad     = 0;
    int bubbles = 0;

    logic [ADDR_W-1:0] qa[$];
    logic [WORD_W-1:0] qd[$];

    s2p_write_ctrl_gen2_if #(
        .IN_W(IN_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .WRAP_CNT_W(WRAP_CNT_W)
    ) bus ();

    s2p_write_ctrl_gen2 #(
        .IN_W(IN_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .WRAP_CNT_W(WRAP_CNT_W)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Record every write strobe mid-cycle.
    always @(negedge clk_in) begin
        if (bus.wr_en === 1'b1) begin
            qa.push_back(bus.wr_addr);
            qd.push_back(bus.wr_data);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [7:0] b);
        if (bus.s_ready !== 1'b1) bubbles++;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        tick();
    endtask

    task automatic do_start(input logic [3:0] base, input logic [3:0] len, input logic oneshot);
        bus.start       = 1'b1;
        bus.cfg_base    = base;
        bus.cfg_len     = len;
        bus.cfg_oneshot = oneshot;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.cfg_base    = '0;
        bus.cfg_len     = '0;
        bus.cfg_oneshot = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
`ifdef S2P_WRITE_CTRL_FLUSH_EN
        bus.flush       = 1'b0;
`endif
        tick();
        tick();
        chk("rst_s_ready",  bus.s_ready,  0);
        chk("rst_wr_en",    bus.wr_en,    0);
        chk("rst_wr_addr",  bus.wr_addr,  0);
        chk("rst_wr_data",  bus.wr_data,  0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_done",     bus.done,     0);
        chk("rst_wrap_cnt", bus.wrap_cnt, 0);
        reset = 1'b0;
        tick();

        // One-shot frame: base 2, three words.
        do_start(4'd2, 4'd3, 1'b1);
        chk("os_busy",    bus.busy,    1);
        chk("os_s_ready", bus.s_ready, 1);
        for (int i = 1; i <= 12; i++) feed(8'(i));
        chk("os_last_wr_en",   bus.wr_en,   1);
        chk("os_last_s_ready", bus.s_ready, 0);
        chk("os_done",         bus.done,    1);
        chk("os_busy_low",     bus.busy,    0);
        bus.s_valid = 1'b0;
        tick();
        chk("os_wr_en_drop", bus.wr_en, 0);
        chk("os_nwrites", qa.size(), 3);
        chk("os_addr0", qa[0], 2);
        chk("os_addr1", qa[1], 3);
        chk("os_addr2", qa[2], 4);
        chk("os_data0", qd[0], 32'h04030201);
        chk("os_data1", qd[1], 32'h08070605);
        chk("os_data2", qd[2], 32'h0C0B0A09);
        chk("os_hold_addr", bus.wr_addr, 4);
        chk("os_hold_data", bus.wr_data, 32'h0C0B0A09);
        qa.delete();
        qd.delete();

        // Wrap mode, same window, 24 back-to-back bytes.
        do_start(4'd2, 4'd3, 1'b0);
        chk("wr_done_clr", bus.done, 0);
        bubbles = 0;
        for (int i = 1; i <= 24; i++) feed(8'(i));
        bus.s_valid = 1'b0;
        tick();
        chk("wr_no_bubble", bubbles, 0);
        chk("wr_nwrites", qa.size(), 6);
        chk("wr_addr0", qa[0], 2);
        chk("wr_addr1", qa[1], 3);
        chk("wr_addr2", qa[2], 4);
        chk("wr_addr3", qa[3], 2);
        chk("wr_addr4", qa[4], 3);
        chk("wr_addr5", qa[5], 4);
        chk("wr_data3", qd[3], 32'h100F0E0D);
        chk("wr_data5", qd[5], 32'h18171615);
        chk("wr_wrap_cnt", bus.wrap_cnt, 2);
        chk("wr_busy", bus.busy, 1);
        qa.delete();
        qd.delete();

        // Wrap mode crossing the top of the 4-bit address space.
        do_start(4'd14, 4'd4, 1'b0);
        chk("aw_wrap_cnt_clr", bus.wrap_cnt, 0);
        for (int i = 0; i < 20; i++) feed(8'h30 + 8'(i));
        bus.s_valid = 1'b0;
        tick();
        chk("aw_nwrites", qa.size(), 5);
        chk("aw_addr0", qa[0], 14);
        chk("aw_addr1", qa[1], 15);
        chk("aw_addr2", qa[2], 0);
        chk("aw_addr3", qa[3], 1);
        chk("aw_addr4", qa[4], 14);
        chk("aw_data2", qd[2], 32'h3B3A3938);
        chk("aw_wrap_cnt", bus.wrap_cnt, 1);
        qa.delete();
        qd.delete();

        // Restart mid-word: partial word and the same-cycle beat are dropped.
        do_start(4'd7, 4'd3, 1'b1);
        feed(8'h55);
        feed(8'h66);
        bus.s_data = 8'h77;
        do_start(4'd5, 4'd3, 1'b1);
        chk("rs_no_write", qa.size(), 0);
        feed(8'hA0);
        feed(8'hA1);
        feed(8'hA2);
        feed(8'hA3);
        bus.s_valid = 1'b0;
        tick();
        chk("rs_nwrites", qa.size(), 1);
        chk("rs_addr", qa[0], 5);
        chk("rs_data", qd[0], 32'hA3A2A1A0);
        qa.delete();
        qd.delete();

        // Reset mid-frame with s_valid held high.
        do_start(4'd1, 4'd2, 1'b0);
        feed(8'h01);
        feed(8'h02);
        feed(8'h03);
        reset = 1'b1;
        tick();
        chk("mr_s_ready",  bus.s_ready,  0);
        chk("mr_wr_en",    bus.wr_en,    0);
        chk("mr_wr_addr",  bus.wr_addr,  0);
        chk("mr_wr_data",  bus.wr_data,  0);
        chk("mr_busy",     bus.busy,     0);
        chk("mr_done",     bus.done,     0);
        chk("mr_wrap_cnt", bus.wrap_cnt, 0);
        reset = 1'b0;
        qa.delete();
        qd.delete();
        for (int i = 0; i < 8; i++) feed(8'hEE);
        bus.s_valid = 1'b0;
        tick();
        chk("mr_idle_no_write", qa.size(), 0);
        chk("mr_idle_s_ready", bus.s_ready, 0);

`ifdef S2P_WRITE_CTRL_FLUSH_EN
        // Flush of a two-beat partial word, then a flush on an empty word.
        qa.delete();
        qd.delete();
        do_start(4'd9, 4'd2, 1'b1);
        feed(8'h11);
        feed(8'h22);
        bus.s_valid = 1'b0;
        bus.flush   = 1'b1;
        tick();
        bus.flush   = 1'b0;
        chk("fl_wr_en",   bus.wr_en,   1);
        chk("fl_wr_addr", bus.wr_addr, 9);
        chk("fl_wr_data", bus.wr_data, 32'h00002211);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        chk("fl_empty_nwrites", qa.size(), 1);
        chk("fl_busy", bus.busy, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s2p_write_ctrl_gen2.md
Name: s2p_write_ctrl_gen2

Overview:
Parametrised successor of the serial-to-parallel write controller. Packs IN_W-bit input beats into WORD_W-bit words and issues one single-cycle write strobe per word, with an address that runs from a programmable base over a programmable length. Runs entirely on clk_in with a write-enable strobe; no derived clocks. Sits between the byte-stream front end and the wide frame buffer memory.

Parameters:
IN_W, 8, input beat width in bits
WORD_W, 2048, output word width; WORD_W/IN_W = BEATS, integer and >= 2
ADDR_W, 12, write address width
WRAP_CNT_W, 8, width of wrap counter

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse; samples cfg_*, arms block
cfg_base  input  ADDR_W  first write address
cfg_len  input  ADDR_W  words per frame; 0 means 2^ADDR_W
cfg_oneshot  input  1  1: stop after one frame; 0: wrap continuously
s_valid  input  1  input beat valid
s_data  input  IN_W  input beat
s_ready  output  1  beat accepted when s_valid && s_ready
wr_en  output  1  one-cycle write strobe
wr_addr  output  ADDR_W  write address, valid with wr_en
wr_data  output  WORD_W  packed word, valid with wr_en
busy  output  1  high in FILL
done  output  1  high in DONE (one-shot frame complete)
wrap_cnt  output  WRAP_CNT_W  completed frames in wrap mode, saturating

Behaviour:
- Reset (clk_in edge with reset=1): state IDLE; s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, wrap_cnt=0, beat_cnt=0, accumulator=0. Reset beats every other input.
- States: IDLE, FILL, DONE.
- IDLE: s_ready=0. start -> FILL; latch cfg_base/cfg_len/cfg_oneshot; addr_ptr=cfg_base, word_idx=0, beat_cnt=0, wrap_cnt=0.
- FILL: s_ready=1, busy=1. Each accepted beat goes to accumulator slot beat_cnt (beat 0 -> bits [IN_W-1:0], LSB-first); beat_cnt++.
- On acceptance of beat BEATS-1: next cycle wr_en=1, wr_data = completed word, wr_addr=addr_ptr; beat_cnt=0. Acceptance continues without a bubble (full throughput, one word per BEATS cycles).
- After each write: addr_ptr = addr_ptr+1 mod 2^ADDR_W; word_idx++. When word_idx reaches latched len (len 0 = 2^ADDR_W):
  - oneshot=0: addr_ptr=base, word_idx=0, wrap_cnt++ (saturates at all-ones), stay FILL.
  - oneshot=1: -> DONE.
  - The frame-closing decision is made in the same cycle the last beat is accepted. In one-shot mode s_ready is already 0 in the following (wr_en) cycle.
- DONE: s_ready=0, done=1, wr_en=0 after the final strobe. start -> FILL (re-arm, done cleared, cfg resampled).
- start while in FILL: restart; partial word discarded (no write); beat accepted in the same cycle is dropped; cfg resampled.
- wr_data and wr_addr hold their last values when wr_en=0.
- Latency: wr_en is 1 cycle after the last beat's accept edge.

Optional Feature:
Macro S2P_WRITE_CTRL_FLUSH_EN.
- Defined: extra input port flush (1 bit). A flush in FILL with beat_cnt>0 and no beat completing a word that cycle writes the partial word next cycle, zero-padded in the unfilled upper slots, with normal address/frame advance. A beat accepted in the same cycle is packed first. Flush is ignored if that beat completes the word, if beat_cnt=0, or outside FILL.
- Undefined: no flush port; partial words are only discarded by start or reset.

Test Plan:
- IN_W=8, WORD_W=32, ADDR_W=4; start base=2, len=3, oneshot=1; feed bytes 0x01..0x0C -> wr_en at addr 2,3,4 with data 0x04030201, 0x08070605, 0x0C0B0A09; then done=1, s_ready=0.
- Same config, oneshot=0, 24 bytes continuous -> addresses 2,3,4,2,3,4, wrap_cnt=2, no s_ready bubble.
- base=14, len=4, wrap mode -> addresses 14,15,0,1,14, with 4-bit address wrap.
- 2 bytes accepted, then start (base=5) -> no write; next 4 bytes 0xA0..0xA3 -> wr_addr=5, data 0xA3A2A1A0.
- Reset asserted mid-frame with s_valid held high -> all outputs return to reset values next edge; no wr_en until a new start.
- FLUSH_EN: bytes 0x11, 0x22 then flush -> wr_en with data 0x00002211 at the base address; flush with beat_cnt=0 -> no write.
